// File: rtl/sram_ctrl.sv
// Single-outstanding load/store controller for a byte-addressed SRAM.
// Three-state handshake: IDLE accepts, ACCESS drives the SRAM, RESP waits.
module sram_ctrl #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        sram_w_en,
  output logic [ADDR_W-1:0] sram_address,
  output logic [31:0]       sram_write_data,
  input  logic [31:0]       sram_read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              sgn;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
  } req_t;

  state_t      state;
  state_t      state_nx;
  req_t        cap_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [3:0]  store_mask;
  logic [31:0] load_fmt;
  logic        size_bad;
  logic        accept;

  assign size_bad = (cap_q.size == 2'b11);
  assign accept   = (state == IDLE) && req_valid;

  always_comb begin
    store_mask = 4'b0000;
    unique case (cap_q.size)
      2'b00: store_mask = 4'b0001;
      2'b01: store_mask = 4'b0011;
      2'b10: store_mask = 4'b1111;
      2'b11: store_mask = 4'b0000;
      default: store_mask = 4'b0000;
    endcase
  end

  // Word loads ignore the sign flag; narrower loads extend bit 7 or 15.
  always_comb begin
    load_fmt = 32'h0;
    unique case (cap_q.size)
      2'b00: load_fmt = {{24{cap_q.sgn & sram_read_data[7]}},
                         sram_read_data[7:0]};
      2'b01: load_fmt = {{16{cap_q.sgn & sram_read_data[15]}},
                         sram_read_data[15:0]};
      2'b10: load_fmt = sram_read_data;
      2'b11: load_fmt = 32'h0;
      default: load_fmt = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    sram_w_en  = 4'b0000;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (cap_q.we) begin
          sram_w_en = store_mask;
        end
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_q <= '0;
    end else if (accept) begin
      cap_q.we    <= req_we;
      cap_q.size  <= req_size;
      cap_q.sgn   <= req_signed;
      cap_q.addr  <= req_addr;
      cap_q.wdata <= req_wdata;
    end
  end

  // Response is latched once at the end of ACCESS and held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (state == ACCESS) begin
      err_q <= size_bad;
      if (cap_q.we || size_bad) begin
        rdata_q <= 32'h0;
      end else begin
        rdata_q <= load_fmt;
      end
    end
  end

  assign resp_rdata      = rdata_q;
  assign resp_err        = err_q;
  assign sram_address    = cap_q.addr;
  assign sram_write_data = cap_q.wdata;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: byte-array SRAM, transaction-level reference model,
// per-cycle output comparison plus directed literal expectations.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = 16'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  sram_w_en;
  logic [15:0] sram_address;
  logic [31:0] sram_write_data;
  logic [31:0] sram_read_data;

  int checks = 0;
  int failures = 0;
  int wcnt = 0;

  sram_ctrl #(.ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_w_en(sram_w_en), .sram_address(sram_address),
    .sram_write_data(sram_write_data),
    .sram_read_data(sram_read_data)
  );

  always #5 clk = ~clk;

  // Environment SRAM: 64 KiB, combinational read, wraps mod 2^16.
  bit [7:0] sram_mem [0:65535];

  assign sram_read_data = {sram_mem[16'(sram_address + 16'd3)],
                           sram_mem[16'(sram_address + 16'd2)],
                           sram_mem[16'(sram_address + 16'd1)],
                           sram_mem[sram_address]};

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (sram_w_en[k]) begin
        sram_mem[16'(sram_address + 16'(k))] <=
          8'(sram_write_data >> (8 * k));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus "which cycle is the access".
  bit [7:0]    ref_mem [0:65535];
  logic        pending = 1'b0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic        m_we = 1'b0;
  logic [1:0]  m_size = 2'b00;
  logic        m_sign = 1'b0;
  logic [15:0] m_addr = 16'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [15:0] last_addr = 16'h0;
  logic [31:0] last_wdata = 32'h0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;

  function automatic logic [31:0] rd_ref(input logic [15:0] a);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++) begin
      w = w | (32'(ref_mem[16'(a + 16'(k))]) << (8 * k));
    end
    return w;
  endfunction

  // Keep the low 8<<size bits, optionally reinterpret as two's complement.
  function automatic logic [31:0] fmt(input logic [31:0] w,
                                      input logic [1:0] sz,
                                      input logic sg);
    longint span;
    longint v;
    span = longint'(1) << (8 << sz);
    v = longint'(w) % span;
    if (sg && sz != 2'd2 && v >= span / 2) v = v - span;
    return 32'(v);
  endfunction

  function automatic logic [3:0] mask_of(input logic [1:0] sz);
    if (sz == 2'b11) return 4'b0000;
    return 4'((1 << (1 << sz)) - 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= 1'b0;
      cyc        <= 0;
      acc_cyc    <= 0;
      last_addr  <= 16'h0;
      last_wdata <= 32'h0;
    end else begin
      cyc <= cyc + 1;
      if (pending && cyc == acc_cyc) begin
        exp_err <= (m_size == 2'b11);
        if (m_size == 2'b11) begin
          exp_rdata <= 32'h0;
        end else if (m_we) begin
          exp_rdata <= 32'h0;
          for (int k = 0; k < (1 << m_size); k++) begin
            ref_mem[16'(m_addr + 16'(k))] <= 8'(m_wdata >> (8 * k));
          end
        end else begin
          exp_rdata <= fmt(rd_ref(m_addr), m_size, m_sign);
        end
      end
      if (pending && cyc > acc_cyc && resp_ready) begin
        pending <= 1'b0;
      end else if (!pending && req_valid) begin
        pending    <= 1'b1;
        acc_cyc    <= cyc + 1;
        m_we       <= req_we;
        m_size     <= req_size;
        m_sign     <= req_signed;
        m_addr     <= req_addr;
        m_wdata    <= req_wdata;
        last_addr  <= req_addr;
        last_wdata <= req_wdata;
      end
    end
  end

  always @(negedge clk) begin
    logic in_acc;
    logic exp_rv;
    in_acc = pending && cyc == acc_cyc;
    exp_rv = pending && cyc > acc_cyc;
    if (sram_w_en != 4'b0000) wcnt++;
    chk("req_ready", 32'(req_ready), 32'(!pending));
    chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
    chk("sram_w_en", 32'(sram_w_en),
        32'((in_acc && m_we) ? mask_of(m_size) : 4'b0000));
    chk("sram_address", 32'(sram_address), 32'(last_addr));
    chk("sram_write_data", sram_write_data, last_wdata);
    if (exp_rv) begin
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
    end
  end

  task automatic txn(input logic we, input logic [1:0] sz,
                     input logic sg, input logic [15:0] a,
                     input logic [31:0] wd, input int hold,
                     input logic [31:0] exp_d, input logic exp_e,
                     input string nm);
    int n;
    logic [31:0] first;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({nm, "_accepted"}, 32'(req_ready), 32'd0);
    n = 0;
    while (!resp_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'd1);
    if (!resp_valid) return;
    first = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_valid"}, 32'(resp_valid), 32'd1);
      chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
      chk({nm, "_hold_data"}, resp_rdata, first);
    end
    chk({nm, "_rdata"}, resp_rdata, exp_d);
    chk({nm, "_err"}, 32'(resp_err), 32'(exp_e));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({nm, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int w0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    w0 = wcnt;
    txn(1, 2'b10, 0, 16'h0010, 32'hDEADBEEF, 0, 32'h0, 0, "st_w");
    chk("st_w_one_cycle", 32'(wcnt - w0), 32'd1);
    txn(0, 2'b10, 0, 16'h0010, 32'h0, 0, 32'hDEADBEEF, 0, "ld_w");
    txn(0, 2'b00, 1, 16'h0013, 32'h0, 0, 32'hFFFFFFDE, 0, "ld_sb");
    txn(0, 2'b01, 0, 16'h0012, 32'h0, 0, 32'h0000DEAD, 0, "ld_uh");
    txn(0, 2'b01, 1, 16'h0010, 32'h0, 0, 32'hFFFFBEEF, 0, "ld_sh");
    txn(0, 2'b00, 0, 16'h0013, 32'h0, 0, 32'h000000DE, 0, "ld_ub");
    txn(0, 2'b10, 1, 16'h0010, 32'h0, 0, 32'hDEADBEEF, 0, "ld_sw");

    txn(1, 2'b10, 0, 16'hFFFE, 32'h11223344, 0, 32'h0, 0, "st_wrap");
    txn(0, 2'b10, 0, 16'hFFFE, 32'h0, 0, 32'h11223344, 0, "ld_wrap");
    txn(0, 2'b00, 0, 16'h0000, 32'h0, 0, 32'h00000022, 0, "ld_b0");

    txn(0, 2'b10, 0, 16'h0010, 32'h0, 5, 32'hDEADBEEF, 0, "ld_hold");

    txn(1, 2'b10, 0, 16'h0020, 32'hCAFEF00D, 0, 32'h0, 0, "st_pre");
    w0 = wcnt;
    txn(1, 2'b11, 0, 16'h0020, 32'hFFFFFFFF, 0, 32'h0, 1, "st_bad");
    chk("st_bad_no_write", 32'(wcnt - w0), 32'd0);
    txn(0, 2'b10, 0, 16'h0020, 32'h0, 0, 32'hCAFEF00D, 0, "ld_post");
    txn(0, 2'b11, 1, 16'h0020, 32'h0, 0, 32'h0, 1, "ld_bad");
    txn(1, 2'b00, 0, 16'h0021, 32'h12345677, 0, 32'h0, 0, "st_b");
    txn(0, 2'b10, 0, 16'h0020, 32'h0, 0, 32'hCAFE770D, 0, "ld_b");
    txn(1, 2'b01, 0, 16'h0041, 32'hFFFF1234, 0, 32'h0, 0, "st_h");
    txn(0, 2'b10, 0, 16'h0040, 32'h0, 0, 32'h00123400, 0, "ld_h");

    txn(1, 2'b10, 0, 16'h0030, 32'h55667788, 0, 32'h0, 0, "st_old");
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 16'h0030; req_wdata = 32'hAAAAAAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_wen_live", 32'(sram_w_en), 32'hF);
    #2 rst = 1'b1;
    #1;
    chk("abort_wen", 32'(sram_w_en), 32'h0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_addr", 32'(sram_address), 32'h0);
    chk("abort_wdata", sram_write_data, 32'h0);
    chk("abort_rdata", resp_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
    end
    txn(0, 2'b10, 0, 16'h0030, 32'h0, 0, 32'h55667788, 0, "ld_abort");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width matching the 64 KiB byte-addressed SRAM.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed  input  1  sign-extend load data (ignored for stores and word loads).
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address, no alignment requirement.
REQ-010 SHALL have port req_wdata  input  32  store data, LSB-aligned.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts response.
REQ-013 SHALL have port resp_rdata  output  32  load result (0 for stores and errors).
REQ-014 SHALL have port resp_err  output  1  illegal-size request.
REQ-015 SHALL have port sram_w_en  output  4  per-byte write enable to SRAM, bit k writes byte at address+k.
REQ-016 SHALL have port sram_address  output  ADDR_W  SRAM byte address.
REQ-017 SHALL have port sram_write_data  output  32  SRAM write data, byte k = bits [8k+7:8k].
REQ-018 SHALL have port sram_read_data  input  32  combinational SRAM read of address..address+3.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RESP; one request in flight at a time.
REQ-020 IDLE: req_ready=1; on req_valid capture we/size/signed/addr/wdata into registers, go ACCESS; else stay.
REQ-021 ACCESS (exactly one cycle): req_ready=0; sram_address=captured addr; sram_write_data=captured wdata; go RESP on next edge.
REQ-022 ACCESS store: sram_w_en = 0001 (byte), 0011 (half), 1111 (word), 0000 (illegal size).
REQ-023 ACCESS load: sram_w_en=0000; at the ACCESS->RESP edge register resp_rdata from sram_read_data.
REQ-024 Load formatting: byte = [7:0], half = [15:0], word = [31:0]; upper bits zero, or copies of bit 7/15 when req_signed=1.
REQ-025 RESP: resp_valid=1; resp_rdata/resp_err held stable until resp_ready=1; on resp_ready go IDLE.
REQ-026 req_ready SHALL be 0 in ACCESS and RESP; a request is never accepted in the cycle its predecessor's response is handshaken.
REQ-027 Latency: request accepted at edge E0 -> ACCESS cycle after E0 -> resp_valid=1 in the cycle after E0+1; minimum issue interval 3 cycles.
REQ-028 sram_w_en SHALL be 0000 in IDLE and RESP; each store writes in exactly one cycle.
REQ-029 Illegal size (11): no SRAM write, resp_err=1, resp_rdata=0; the FSM path is otherwise identical.
REQ-030 Store response: resp_rdata=0, resp_err=0.
REQ-031 Address wrap: no alignment check; addresses near 0xFFFF pass unchanged, and the SRAM wraps bytes mod 2^ADDR_W.
REQ-032 sram_address and sram_write_data SHALL hold the last captured values outside ACCESS.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, sram_w_en=0000, sram_address=0, sram_write_data=0, and all capture registers to 0.
REQ-034 Reset during ACCESS or RESP SHALL abort the transaction: no write occurs if rst is asserted before the ACCESS edge, and the pending response is discarded.
REQ-035 After rst deasserts, the first request SHALL be accepted in the first cycle req_valid=1.

Verification
REQ-036 Word store 0xDEADBEEF @0x0010 -> sram_w_en=1111 for exactly 1 cycle, resp_err=0; word load @0x0010 -> resp_rdata=0xDEADBEEF.
REQ-037 After REQ-036: signed byte load @0x0013 -> 0xFFFFFFDE; unsigned half load @0x0012 -> 0x0000DEAD; signed half @0x0010 -> 0xFFFFBEEF.
REQ-038 Word store 0x11223344 @0xFFFE, then word load @0xFFFE -> 0x11223344; byte load @0x0000 -> 0x00000022.
REQ-039 Hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid=1 and resp_rdata stable throughout, req_ready=0; release -> IDLE next cycle.
REQ-040 Store with req_size=11 @0x0020 -> sram_w_en stays 0000, resp_err=1, resp_rdata=0; a following word load @0x0020 returns the prior contents.
REQ-041 Store 0xAAAAAAAA @0x0030, rst pulse in ACCESS before the edge -> no write, resp_valid never asserts; a later load @0x0030 returns the old value.
